pos_cell_access_ctrl: RTL and testbench

Sequencing and arbitration controller for one cell position memory (single-port RAM, 2-cycle read latency, address 0 = particle count, addresses 1..count = `{posz, posy, posx}`). It sits between the cell memory and its two users. The force-evaluation side asks it to stream the whole cell. The motion-update side writes positions back. The block serialises the two users onto the single port, with reads taking priority.

---
 rtl/pos_cell_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pos_cell_access_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_cell_access_ctrl.sv
// Cell position memory controller: streams a whole cell to the force side and
// serialises motion-update writes onto the same single-port RAM, reads first.
module pos_cell_access_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_particle_id,
    output logic                  out_last,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_rden_q, mem_rden_d;
    logic                  mem_wren_q, mem_wren_d;
    logic                  vld1_q, vld1_d;
    logic                  vld2_q, vld2_d;
    logic [ADDR_WIDTH-1:0] id1_q, id1_d;
    logic [ADDR_WIDTH-1:0] id2_q, id2_d;

    logic [ADDR_WIDTH-1:0] count_clamped;
    logic                  write_grant;

    always_comb begin
        count_clamped = mem_q[ADDR_WIDTH-1:0];
        if (mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) begin
            count_clamped = MAX_COUNT;
        end
    end

    // A read request in the same cycle always takes the port; the write waits.
    always_comb begin
        write_grant = (state_q == IDLE) && wr_req && !rd_start && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            phase_q       <= 1'b0;
            count_q       <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            vld1_q        <= 1'b0;
            vld2_q        <= 1'b0;
            id1_q         <= '0;
            id2_q         <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            count_q       <= count_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_rden_q    <= mem_rden_d;
            mem_wren_q    <= mem_wren_d;
            vld1_q        <= vld1_d;
            vld2_q        <= vld2_d;
            id1_q         <= id1_d;
            id2_q         <= id2_d;
        end
    end

    // Memory controls are registered, so they are decided on the transition
    // into the state that owns them.
    always_comb begin
        state_d       = state_q;
        phase_d       = 1'b0;
        count_d       = count_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_rden_d    = 1'b0;
        mem_wren_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d       = RD_CNT;
                    mem_rden_d    = 1'b1;
                    mem_address_d = '0;
                end else if (write_grant) begin
                    mem_wren_d    = 1'b1;
                    mem_address_d = wr_addr;
                    mem_data_d    = wr_data;
                end
            end
            RD_CNT: begin
                state_d = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    count_d = count_clamped;
                    if (count_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d       = STREAM;
                        mem_rden_d    = 1'b1;
                        mem_address_d = ADDR_WIDTH'(1);
                    end
                end
            end
            STREAM: begin
                if (mem_address_q == count_q) begin
                    state_d = DRAIN;
                end else begin
                    mem_rden_d    = 1'b1;
                    mem_address_d = mem_address_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Two-stage tag pipeline lines the particle id up with the RAM read latency.
    always_comb begin
        vld1_d = (state_q == STREAM) && mem_rden_q;
        id1_d  = mem_address_q;
        vld2_d = vld1_q;
        id2_d  = id1_q;
    end

    always_comb begin
        rd_busy         = (state_q != IDLE) && (state_q != DONE);
        rd_done         = (state_q == DONE);
        particle_count  = count_q;
        out_valid       = vld2_q;
        out_data        = vld2_q ? mem_q : '0;
        out_particle_id = vld2_q ? id2_q : '0;
        out_last        = vld2_q && (id2_q == count_q);
        wr_ack          = write_grant;
        mem_address     = mem_address_q;
        mem_data        = mem_data_q;
        mem_rden        = mem_rden_q;
        mem_wren        = mem_wren_q;
    end

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Bench for pos_cell_access_ctrl: a 2-cycle-latency RAM model plus a cycle-offset
// reference of the read/write protocol, driven by directed and random cells.
module tb_pos_cell_access_ctrl;

    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_start;
    logic          rd_busy;
    logic          rd_done;
    logic [AW-1:0] particle_count;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_particle_id;
    logic          out_last;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    logic [DW-1:0] ram     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] rd1;

    int            checks;
    int            errors;
    logic [AW-1:0] model_pc;

    always #5 clk = ~clk;

    pos_cell_access_ctrl #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_start       (rd_start),
        .rd_busy        (rd_busy),
        .rd_done        (rd_done),
        .particle_count (particle_count),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_particle_id(out_particle_id),
        .out_last       (out_last),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_rden       (mem_rden),
        .mem_wren       (mem_wren),
        .mem_q          (mem_q)
    );

    // Single-port RAM: read data appears two cycles after the enable.
    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        if (mem_wren) ram[mem_address] <= mem_data;
        if (rst) begin
            rd1   <= '0;
            mem_q <= '0;
        end else begin
            if (mem_rden) rd1 <= ram[mem_address];
            mem_q <= rd1;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input logic [DW-1:0] d);
        pl_we   = 1'b1;
        pl_addr = AW'(addr);
        pl_data = d;
        ref_mem[addr] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic load_cell(input int n_raw, input int nwords);
        load(0, DW'(n_raw));
        for (int i = 1; i <= nwords; i++) begin
            load(i, {$urandom(), $urandom(), $urandom()});
        end
    endtask

    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            #1;
            chk("idle_rd_busy", DW'(rd_busy), '0);
            chk("idle_rd_done", DW'(rd_done), '0);
            chk("idle_count", DW'(particle_count), '0);
            chk("idle_out_valid", DW'(out_valid), '0);
            chk("idle_out_data", out_data, '0);
            chk("idle_out_id", DW'(out_particle_id), '0);
            chk("idle_out_last", DW'(out_last), '0);
            chk("idle_wr_ack", DW'(wr_ack), '0);
            chk("idle_mem_addr", DW'(mem_address), '0);
            chk("idle_mem_data", mem_data, '0);
            chk("idle_mem_rden", DW'(mem_rden), '0);
            chk("idle_mem_wren", DW'(mem_wren), '0);
            @(negedge clk);
        end
    endtask

    // k is the cycle offset from the rd_start cycle; expectations come from the
    // documented timeline, the count in ref_mem[0] and the reference contents.
    task automatic do_read(input int rst_at, input int wr_from,
                           input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
        int            n;
        int            end_k;
        int            ack_k;
        bit            pend;
        bit            after_rst;
        bit            exp_idle;
        bit            exp_ack;
        bit            exp_v;
        bit            exp_rd;
        logic [AW-1:0] old_pc;
        logic [7:0]    raw;
        raw    = ref_mem[0][7:0];
        n      = (int'(raw) > PN - 1) ? PN - 1 : int'(raw);
        end_k  = (n == 0) ? 4 : 6 + n;
        ack_k  = -1;
        pend   = (wr_from >= 0);
        old_pc = model_pc;
        for (int k = 0; k <= end_k + 3; k++) begin
            rd_start = (k == 0);
            rst      = (k == rst_at);
            wr_req   = pend && (k >= wr_from);
            wr_addr  = waddr;
            wr_data  = wdata;
            #1;
            after_rst = (rst_at >= 0) && (k > rst_at);
            exp_idle  = (k == 0) || (k > end_k) || after_rst;
            exp_ack   = wr_req && exp_idle && !rd_start && !rst;
            chk("wr_ack", DW'(wr_ack), DW'(exp_ack));
            if (after_rst) begin
                chk("rst_rd_busy", DW'(rd_busy), '0);
                chk("rst_rd_done", DW'(rd_done), '0);
                chk("rst_out_valid", DW'(out_valid), '0);
                chk("rst_out_last", DW'(out_last), '0);
                chk("rst_mem_rden", DW'(mem_rden), '0);
                chk("rst_count", DW'(particle_count), '0);
            end else begin
                chk("rd_busy", DW'(rd_busy), DW'(k >= 1 && k < end_k));
                chk("rd_done", DW'(rd_done), DW'(k == end_k));
                exp_v = (n > 0) && (k >= 6) && (k <= 5 + n);
                chk("out_valid", DW'(out_valid), DW'(exp_v));
                if (exp_v) begin
                    chk("out_id", DW'(out_particle_id), DW'(k - 5));
                    chk("out_data", out_data, ref_mem[k-5]);
                    chk("out_last", DW'(out_last), DW'(k == 5 + n));
                end else begin
                    chk("out_last_idle", DW'(out_last), '0);
                end
                exp_rd = (k == 1) || ((k >= 4) && (k <= 3 + n));
                chk("mem_rden", DW'(mem_rden), DW'(exp_rd));
                if (exp_rd) begin
                    chk("mem_rd_addr", DW'(mem_address), DW'((k == 1) ? 0 : k - 3));
                end
                chk("particle_count", DW'(particle_count), DW'((k >= 4) ? AW'(n) : old_pc));
            end
            chk("mem_wren", DW'(mem_wren), DW'((ack_k >= 0) && (k == ack_k + 1)));
            if ((ack_k >= 0) && (k == ack_k + 1)) begin
                chk("mem_wr_addr", DW'(mem_address), DW'(waddr));
                chk("mem_wr_data", mem_data, wdata);
            end
            if (exp_ack) begin
                ack_k = k;
                pend  = 1'b0;
                ref_mem[waddr] = wdata;
            end
            @(negedge clk);
        end
        rd_start = 1'b0;
        rst      = 1'b0;
        wr_req   = 1'b0;
        model_pc = (rst_at >= 0) ? '0 : AW'(n);
    endtask

    initial begin
        int nr;
        checks   = 0;
        errors   = 0;
        model_pc = '0;
        rst      = 1'b1;
        rd_start = 1'b0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        pl_we    = 1'b0;
        pl_addr  = '0;
        pl_data  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_check(10);

        load_cell(3, 3);
        do_read(-1, -1, '0, '0);

        load_cell(0, 0);
        do_read(-1, -1, '0, '0);

        load_cell(250, 219);
        do_read(-1, -1, '0, '0);

        load_cell(3, 3);
        do_read(-1, 2, 8'd2, {$urandom(), $urandom(), $urandom()});
        do_read(-1, -1, '0, '0);

        do_read(-1, 0, 8'd0, DW'(2));
        do_read(-1, -1, '0, '0);

        load_cell(3, 3);
        do_read(7, -1, '0, '0);
        do_read(-1, -1, '0, '0);

        for (int r = 0; r < 6; r++) begin
            nr = int'($urandom_range(0, 12));
            load_cell(nr, nr);
            if (r % 2 == 0) begin
                do_read(-1, int'($urandom_range(0, 8)), AW'($urandom_range(1, 15)),
                        {$urandom(), $urandom(), $urandom()});
            end else begin
                do_read(-1, -1, '0, '0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
